// File: rtl/imem_fetch_arbiter_if.sv
// Fetch, loader and memory-side signals of the instruction memory arbiter.
// The slave modport faces the arbiter; the master modport faces its environment.
interface imem_fetch_arbiter_if #(
  parameter int ADDR_W = 6
);
  logic              fetch_req;
  logic [31:0]       fetch_pc;
  logic              fetch_gnt;
  logic              fetch_valid;
  logic [31:0]       fetch_instr;
  logic              fetch_err;
  logic              flush;
  logic              load_valid;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        load_data;
  logic              load_ready;
  logic              load_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              busy;

  modport slave (
    input  fetch_req, fetch_pc, flush,
    input  load_valid, load_addr, load_data,
    input  mem_rdata,
    output fetch_gnt, fetch_valid, fetch_instr,
    output fetch_err, load_ready, load_err,
    output mem_addr, mem_we, mem_wdata, busy
  );

  modport master (
    output fetch_req, fetch_pc, flush,
    output load_valid, load_addr, load_data,
    output mem_rdata,
    input  fetch_gnt, fetch_valid, fetch_instr,
    input  fetch_err, load_ready, load_err,
    input  mem_addr, mem_we, mem_wdata, busy
  );
endinterface

// File: rtl/imem_fetch_arbiter.sv
// Shares a byte-wide sync-read instruction memory between fetch and loader.
// Fetches assemble four byte reads into a little-endian 32-bit word.
module imem_fetch_arbiter #(
  parameter int          MEM_BYTES = 36,
  parameter int          ADDR_W    = 6,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic clk,
  input logic reset,
  imem_fetch_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;
  typedef enum logic {LOAD, FETCH} req_t;

  localparam logic [32:0] LAST = 33'(MEM_BYTES - 1);

  state_t            state_q, state_d;
  req_t              last_q, last_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              err_q, err_d;
  logic [23:0]       sh_q, sh_d;
  logic [31:0]       instr_q, instr_d;

  logic f_el, l_el, f_win, l_win, pc_bad;

  // 33-bit add so a pc near 2**32 cannot wrap into range
  assign pc_bad = (bus.fetch_pc[1:0] != 2'b00) ||
                  (({1'b0, bus.fetch_pc} + 33'd3) > LAST);

  assign f_el  = bus.fetch_req & ~bus.flush;
  assign l_el  = bus.load_valid;
  assign f_win = f_el & (~l_el | (last_q == LOAD));
  assign l_win = l_el & ~f_win;

  assign bus.fetch_instr = instr_q;
  assign bus.busy        = (state_q != IDLE);

  always_comb begin
    state_d         = state_q;
    last_d          = last_q;
    cnt_d           = cnt_q;
    pc_d            = pc_q;
    err_d           = err_q;
    sh_d            = sh_q;
    instr_d         = instr_q;
    bus.fetch_gnt   = 1'b0;
    bus.fetch_valid = 1'b0;
    bus.fetch_err   = 1'b0;
    bus.load_ready  = 1'b0;
    bus.load_err    = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_we      = 1'b0;
    bus.mem_wdata   = 8'h00;
    unique case (state_q)
      IDLE: begin
        if (f_win) begin
          bus.fetch_gnt = 1'b1;
          last_d        = FETCH;
          pc_d          = bus.fetch_pc[ADDR_W-1:0];
          err_d         = pc_bad;
          cnt_d         = 3'd0;
          if (pc_bad) begin
            state_d = DONE;
            instr_d = NOP_INSTR;
          end else begin
            state_d = READ;
          end
        end else if (l_win) begin
          bus.load_ready = 1'b1;
          last_d         = LOAD;
          if (int'(bus.load_addr) < MEM_BYTES) begin
            bus.mem_we    = 1'b1;
            bus.mem_addr  = bus.load_addr;
            bus.mem_wdata = bus.load_data;
          end else begin
            bus.load_err = 1'b1;
          end
        end
      end
      READ: begin
        if (cnt_q < 3'd4) begin
          bus.mem_addr = pc_q + ADDR_W'(cnt_q);
        end
        if (cnt_q == 3'd4) begin
          instr_d = {bus.mem_rdata, sh_q};
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q != 3'd0) begin
            sh_d = {bus.mem_rdata, sh_q[23:8]};
          end
        end
        if (bus.flush) begin
          state_d = IDLE;
          instr_d = instr_q;
        end
      end
      DONE: begin
        bus.fetch_valid = ~bus.flush;
        bus.fetch_err   = err_q & ~bus.flush;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= LOAD;
      cnt_q   <= 3'd0;
      pc_q    <= '0;
      err_q   <= 1'b0;
      sh_q    <= 24'h0;
      instr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      sh_q    <= sh_d;
      instr_q <= instr_d;
    end
  end
endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Randomized scoreboard bench for imem_fetch_arbiter.
// A byte-array memory model sits behind the DUT's memory port.
module tb_imem_fetch_arbiter;
  localparam int MEM = 36;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    int          t;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic errchk = 1'b0;
  logic [31:0] last_instr;
  logic        last_err;

  logic [7:0] mem [64];
  logic [7:0] ref_mem [64];
  exp_t q [$];
  bit   glog [$];

  imem_fetch_arbiter_if #(.ADDR_W(6)) b ();

  imem_fetch_arbiter #(
    .MEM_BYTES(MEM), .ADDR_W(6), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .reset(reset), .bus(b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    b.mem_rdata <= mem[b.mem_addr];
    if (b.mem_we) mem[b.mem_addr] <= b.mem_wdata;
  end

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic timeout(input string n);
    total++;
    bad++;
    $display("FAIL %s timed out t=%0t", n, $time);
  endtask

  // feeder: expected results are taken from the reference memory at grant
  always @(negedge clk) begin
    exp_t e;
    logic [63:0] top;
    int p;
    if (!reset) begin
      if (b.fetch_req && b.fetch_gnt) begin
        glog.push_back(1'b1);
        top = {32'h0, b.fetch_pc} + 64'd3;
        e.t = cyc;
        e.err = (b.fetch_pc % 4 != 0) || (top >= 64'(MEM));
        if (e.err) begin
          e.instr = NOP;
          e.lat = 1;
        end else begin
          p = int'(b.fetch_pc);
          e.instr = {ref_mem[p+3], ref_mem[p+2], ref_mem[p+1], ref_mem[p]};
          e.lat = 6;
        end
        q.push_back(e);
      end
      if (b.load_valid && b.load_ready) begin
        glog.push_back(1'b0);
        if (int'(b.load_addr) < MEM) ref_mem[b.load_addr] = b.load_data;
      end
    end
  end

  // monitor
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      q.delete();
    end else begin
      if (b.fetch_valid) begin
        if (q.size() == 0) begin
          timeout("unexpected_fetch_valid");
        end else begin
          e = q.pop_front();
          chk("fetch_instr", b.fetch_instr, e.instr);
          chk("fetch_err", 32'(b.fetch_err), 32'(e.err));
          chk("fetch_latency", cyc - e.t, e.lat);
          last_instr = b.fetch_instr;
          last_err = b.fetch_err;
        end
      end else if (b.busy && b.flush && q.size() > 0) begin
        void'(q.pop_front());
      end
      if (b.busy)
        chk("no_grant_busy", {b.fetch_gnt, b.load_ready}, 0);
      if (b.load_ready || b.mem_we)
        chk("mem_we", 32'(b.mem_we),
            32'(b.load_ready && int'(b.load_addr) < MEM));
      if (errchk)
        chk("err_fetch_mem", {b.mem_we, 26'h0, b.mem_addr}, 0);
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((b.busy || q.size() > 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) timeout("wait_idle");
  endtask

  task automatic do_load(input logic [5:0] a, input logic [7:0] d);
    int n = 0;
    b.load_valid = 1'b1;
    b.load_addr = a;
    b.load_data = d;
    @(negedge clk);
    while (!b.load_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) timeout("load_ready");
    @(posedge clk);
    #1;
    b.load_valid = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] pc, input int k);
    int n = 0;
    b.fetch_req = 1'b1;
    b.fetch_pc = pc;
    @(negedge clk);
    while (!b.fetch_gnt && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) timeout("fetch_gnt");
    @(posedge clk);
    #1;
    b.fetch_req = 1'b0;
    if (k > 0) begin
      repeat (k - 1) @(posedge clk);
      #1;
      b.flush = 1'b1;
      @(posedge clk);
      #1;
      b.flush = 1'b0;
      @(negedge clk);
      chk("flush_busy", 32'(b.busy), 0);
    end
    wait_idle();
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    reset = 1'b1;
    b.fetch_req = 1'b0;
    b.fetch_pc = 32'h0;
    b.flush = 1'b0;
    b.load_valid = 1'b0;
    b.load_addr = '0;
    b.load_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(b.busy), 0);
    chk("rst_instr", b.fetch_instr, 0);
    chk("rst_outs", {b.fetch_valid, b.fetch_gnt, b.load_ready,
                     b.mem_we, b.load_err, b.fetch_err}, 0);
    chk("rst_mem", {b.mem_wdata, 18'h0, b.mem_addr}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    do_load(6'd0, 8'h20);
    do_load(6'd1, 8'h10);
    do_load(6'd2, 8'h01);
    do_load(6'd3, 8'h00);
    do_fetch(32'd0, 0);
    chk("first_word", last_instr, 32'h0001_1020);

    errchk = 1'b1;
    do_fetch(32'd2, 0);
    errchk = 1'b0;
    chk("misalign_err", 32'(last_err), 1);
    chk("misalign_nop", last_instr, NOP);

    for (int i = 32; i < 36; i++) do_load(6'(i), 8'($urandom));
    do_fetch(32'd32, 0);
    chk("pc32_ok", 32'(last_err), 0);
    do_fetch(32'd36, 0);
    chk("pc36_err", 32'(last_err), 1);
    do_fetch(32'hFFFF_FFFC, 0);
    chk("pc_wrap_err", 32'(last_err), 1);

    pulse_reset();
    glog.delete();
    b.fetch_req = 1'b1;
    b.fetch_pc = 32'd0;
    b.load_valid = 1'b1;
    b.load_addr = 6'd5;
    b.load_data = 8'h55;
    for (int i = 0; i < 60 && glog.size() < 3; i++) @(negedge clk);
    @(posedge clk);
    #1;
    b.fetch_req = 1'b0;
    b.load_valid = 1'b0;
    if (glog.size() < 3) timeout("arb_grants");
    else chk("arb_order", {29'h0, glog[0], glog[1], glog[2]}, 3'b101);
    wait_idle();

    b.fetch_req = 1'b1;
    b.flush = 1'b1;
    b.load_valid = 1'b1;
    b.load_addr = 6'd6;
    b.load_data = 8'h66;
    @(negedge clk);
    chk("flush_idle_gnt", {b.fetch_gnt, b.load_ready}, 2'b01);
    @(posedge clk);
    #1;
    b.fetch_req = 1'b0;
    b.flush = 1'b0;
    b.load_valid = 1'b0;

    do_fetch(32'd8, 3);
    do_fetch(32'd0, 0);
    chk("post_flush_word", last_instr, 32'h0001_1020);

    b.load_valid = 1'b1;
    b.load_addr = 6'd40;
    b.load_data = 8'hAA;
    @(negedge clk);
    chk("oob_load", {b.load_ready, b.load_err, b.mem_we}, 3'b110);
    @(posedge clk);
    #1;
    b.load_valid = 1'b0;

    b.fetch_req = 1'b1;
    b.fetch_pc = 32'd4;
    @(negedge clk);
    chk("mid_gnt", 32'(b.fetch_gnt), 1);
    @(posedge clk);
    #1;
    b.fetch_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_busy", 32'(b.busy), 0);
    chk("mid_rst_instr", b.fetch_instr, 0);
    chk("mid_rst_outs", {b.fetch_valid, b.fetch_err, b.mem_we,
                         26'h0, b.mem_addr}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int it = 0; it < 90; it++) begin
      int r;
      int k;
      logic [31:0] pc;
      r = $urandom_range(0, 9);
      if (r < 4) begin
        do_load(6'($urandom_range(0, 39)), 8'($urandom));
      end else begin
        if (r == 9) pc = $urandom;
        else pc = 32'(4 * $urandom_range(0, 9));
        if (r == 8) pc = pc + 32'd1;
        k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
        do_fetch(pc, k);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
